irq_watchdog_timer: RTL and testbench

//  Timing/supervision stage beside the CPU address decoder. Divides clk_en into the
//  3 kHz status bit that the decoder returns on reads of 0x0C00 bit 7. Raises the

---
 rtl/core_timing_pkg.sv | 24 ++
 rtl/irq_watchdog_timer_if.sv | 17 +
 rtl/clk_en_prescaler.sv | 32 +++
 rtl/irq_watchdog_timer.sv | 147 ++++++++++++++
 tb/tb_irq_watchdog_timer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_timing_pkg.sv
// Shared timing/supervision definitions.
//  wdog_state_t    : watchdog FSM state (WD_RUN counts IRQ periods, WD_HOLD holds cpu_rst)
//  WDOG_ADDR_DEF   : default write address that kicks the watchdog
//  IRQACK_ADDR_DEF : default write address that clears a pending IRQ
//  wr_hit()        : one-cycle CPU write strobe decode for a single address
package core_timing_pkg;

   typedef enum logic {
      WD_RUN  = 1'b0,
      WD_HOLD = 1'b1
   } wdog_state_t;

   localparam logic [15:0] WDOG_ADDR_DEF   = 16'h5000;
   localparam logic [15:0] IRQACK_ADDR_DEF = 16'h5000;

   // True only in an enabled CPU cycle that writes exactly the given address.
   function automatic logic wr_hit(input logic        en,
                                   input logic        we,
                                   input logic [15:0] addr,
                                   input logic [15:0] match);
      return en & we & (addr == match);
   endfunction

endpackage

// File: rtl/irq_watchdog_timer_if.sv
// CPU bus view shared with the address decoder.
//  clk_en : CPU clock enable; a bus cycle exists only when it is 1
//  addr   : 16-bit CPU address
//  we     : CPU write strobe
// Bus semantics: there is no valid/ready pair on this bus. A write is taken
// exactly once in every clk cycle where clk_en=1 and we=1; the slave can never
// stall the CPU, and addr/we are ignored whenever clk_en=0.
interface irq_watchdog_timer_if;

   logic        clk_en;
   logic [15:0] addr;
   logic        we;

   modport master (output clk_en, output addr, output we);
   modport slave  (input  clk_en, input  addr, input  we);

endinterface

// File: rtl/clk_en_prescaler.sv
// Enable-gated N-bit free-running up counter.
//  clk, rst  : system clock, synchronous active-low reset
//  clk_en    : count enable (+1 per enabled cycle, wraps 2^N-1 -> 0)
//  count     : current counter value (registered)
//  msb       : count[N-1], a divided clock with period 2^N enables
//  msb_rise  : one-cycle pulse in the enabled cycle whose edge drives msb 0->1
module clk_en_prescaler #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   output logic [N-1:0] count,
   output logic         msb,
   output logic         msb_rise
);

   // Value one enable before the msb rises: 0111...1
   localparam logic [N-1:0] PRE_RISE = {1'b0, {(N-1){1'b1}}};

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clk_en) begin
         count <= count + N'(1);
      end
   end

   assign msb      = count[N-1];
   assign msb_rise = clk_en & (count == PRE_RISE);

endmodule

// File: rtl/irq_watchdog_timer.sv
// Timing/supervision stage beside the CPU address decoder.
//  clk, rst       : system clock, synchronous active-low reset
//  bus            : CPU bus (clk_en, addr, we), slave side
//  wdog_disable   : 1 holds the watchdog period count at 0
//  clk_3KHz       : divided status clock returned by the decoder
//  irq_n          : active-low periodic IRQ level to the CPU
//  cpu_rst        : active-high core reset request from the watchdog
//  wdog_fired     : sticky, watchdog fired since reset
//  irq_overrun    : sticky, an IRQ period ended with the IRQ still pending
//  wdog_state     : watchdog FSM state (debug visibility)
//  dbg_prescale   : raw prescaler count (debug visibility)
module irq_watchdog_timer
   import core_timing_pkg::*;
#(
   parameter int          PRESCALE_BITS = 9,
   parameter int          IRQ_DIV       = 12,
   parameter int          WDOG_LIMIT    = 8,
   parameter int          RST_HOLD      = 16,
   parameter logic [15:0] WDOG_ADDR     = WDOG_ADDR_DEF,
   parameter logic [15:0] IRQACK_ADDR   = IRQACK_ADDR_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   irq_watchdog_timer_if.slave      bus,
   input  logic                     wdog_disable,
   output logic                     clk_3KHz,
   output logic                     irq_n,
   output logic                     cpu_rst,
   output logic                     wdog_fired,
   output logic                     irq_overrun,
   output wdog_state_t              wdog_state,
   output logic [PRESCALE_BITS-1:0] dbg_prescale
);

   // One spare bit on each counter so the terminal count is representable.
   localparam int WCNT_W = $clog2(WDOG_LIMIT) + 1;
   localparam int HCNT_W = $clog2(RST_HOLD) + 1;
   localparam int DIV_W  = $clog2(IRQ_DIV) + 1;

   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WDOG_LIMIT - 1);
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(RST_HOLD - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(IRQ_DIV - 1);

   logic [PRESCALE_BITS-1:0] pre_count;
   logic                     pre_msb;
   logic                     pre_rise;
   logic [DIV_W-1:0]         irq_div;
   logic [WCNT_W-1:0]        wcnt;
   logic [HCNT_W-1:0]        hcnt;
   wdog_state_t              state;
   logic                     ack;
   logic                     kick;
   logic                     period_tick;
   logic                     wd_fire;

   clk_en_prescaler #(.N(PRESCALE_BITS)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (bus.clk_en),
      .count    (pre_count),
      .msb      (pre_msb),
      .msb_rise (pre_rise)
   );

   // The prescaler msb is already a flop, so the status clock is registered.
   assign clk_3KHz     = pre_msb;
   assign dbg_prescale = pre_count;
   assign wdog_state   = state;

   assign ack  = wr_hit(bus.clk_en, bus.we, bus.addr, IRQACK_ADDR);
   assign kick = wr_hit(bus.clk_en, bus.we, bus.addr, WDOG_ADDR);

   assign period_tick = pre_rise & (irq_div == DIV_LAST);

   // A kick or disable in the same cycle as the terminal tick saves the CPU.
   assign wd_fire = (state == WD_RUN) & period_tick & ~kick & ~wdog_disable &
                    (wcnt == WCNT_LAST);

   // Counts status-clock rising edges; keeps running through a reset hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_div <= '0;
      end else if (pre_rise) begin
         irq_div <= (irq_div == DIV_LAST) ? '0 : irq_div + DIV_W'(1);
      end
   end

   // Watchdog FSM plus the IRQ pending flag. irq_n is the inverted pending
   // flag held directly in its output flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= WD_RUN;
         wcnt        <= '0;
         hcnt        <= '0;
         cpu_rst     <= 1'b0;
         wdog_fired  <= 1'b0;
         irq_n       <= 1'b1;
         irq_overrun <= 1'b0;
      end else if (bus.clk_en) begin
         case (state)
            WD_RUN: begin
               if (kick || wdog_disable) begin
                  wcnt <= '0;
               end else if (period_tick) begin
                  if (wd_fire) begin
                     state      <= WD_HOLD;
                     wcnt       <= '0;
                     hcnt       <= '0;
                     cpu_rst    <= 1'b1;
                     wdog_fired <= 1'b1;
                  end else begin
                     wcnt <= wcnt + WCNT_W'(1);
                  end
               end

               // Set beats ack; the core is about to be reset on a fire,
               // so no IRQ is raised into it.
               if (wd_fire) begin
                  irq_n <= 1'b1;
               end else if (period_tick) begin
                  irq_n <= 1'b0;
                  if (!irq_n) begin
                     irq_overrun <= 1'b1;
                  end
               end else if (ack) begin
                  irq_n <= 1'b1;
               end
            end

            WD_HOLD: begin
               irq_n <= 1'b1;
               if (hcnt == HCNT_LAST) begin
                  state   <= WD_RUN;
                  cpu_rst <= 1'b0;
               end else begin
                  hcnt <= hcnt + HCNT_W'(1);
               end
            end

            default: begin
               state <= WD_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_watchdog_timer.sv
// Bench for irq_watchdog_timer, built with shortened periods so every
// scenario fits a short run: 32-enable status clock, 3 rises per IRQ period,
// 4 periods to starve the watchdog, 6-enable reset hold.
module tb_irq_watchdog_timer;
   import core_timing_pkg::*;

   localparam int          PB   = 5;
   localparam int          DIVP = 3;
   localparam int          WL   = 4;
   localparam int          RH   = 6;
   localparam int          P    = 1 << PB;
   localparam logic [15:0] WA   = WDOG_ADDR_DEF;
   localparam logic [15:0] AA   = IRQACK_ADDR_DEF;

   // ---------------- clock / reset / DUT ----------------
   logic          clk;
   logic          rst;
   logic          wdog_disable;
   logic          clk_3KHz;
   logic          irq_n;
   logic          cpu_rst;
   logic          wdog_fired;
   logic          irq_overrun;
   wdog_state_t   wdog_state;
   logic [PB-1:0] dbg_prescale;

   irq_watchdog_timer_if bus ();

   irq_watchdog_timer #(
      .PRESCALE_BITS (PB),
      .IRQ_DIV       (DIVP),
      .WDOG_LIMIT    (WL),
      .RST_HOLD      (RH),
      .WDOG_ADDR     (WA),
      .IRQACK_ADDR   (AA)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .wdog_disable (wdog_disable),
      .clk_3KHz     (clk_3KHz),
      .irq_n        (irq_n),
      .cpu_rst      (cpu_rst),
      .wdog_fired   (wdog_fired),
      .irq_overrun  (irq_overrun),
      .wdog_state   (wdog_state),
      .dbg_prescale (dbg_prescale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit rst_seen = 0;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   // ---------------- reference model ----------------
   // State is kept as "enables since reset", "periods since last kick" and
   // "hold enables remaining"; the status clock and IRQ period are derived
   // arithmetically from the enable count.
   int m_n;
   int m_periods;
   int m_hold_left;
   bit m_hold;
   bit m_pending;
   bit m_ovr;
   bit m_fired;
   bit m_tick;

   // Period ends on the enable that raises the status clock for the
   // DIVP-th, 2*DIVP-th, ... time.
   function automatic bit tick_at(input int n);
      return ((n % P) == (P / 2)) && ((((n / P) + 1) % DIVP) == 0);
   endfunction

   task automatic model_step();
      bit kick, ack, clr;
      m_tick = 0;
      if (!rst) begin
         m_n = 0; m_periods = 0; m_hold_left = 0; m_hold = 0;
         m_pending = 0; m_ovr = 0; m_fired = 0;
      end else if (bus.clk_en) begin
         m_n++;
         m_tick = tick_at(m_n);
         kick = bus.we && (bus.addr == WA);
         ack  = bus.we && (bus.addr == AA);
         clr  = kick || wdog_disable;
         if (m_hold) begin
            m_pending = 0;
            m_hold_left--;
            if (m_hold_left == 0) m_hold = 0;
         end else if (m_tick && !clr && (m_periods == WL - 1)) begin
            m_hold = 1; m_hold_left = RH; m_fired = 1;
            m_periods = 0; m_pending = 0;
         end else begin
            if (clr) m_periods = 0;
            else if (m_tick) m_periods++;
            if (m_tick) begin
               if (m_pending) m_ovr = 1;
               m_pending = 1;
            end else if (ack) begin
               m_pending = 0;
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: DUT and model both take the edge, outputs compared 1 ns later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      if (cpu_rst === 1'b1) rst_seen = 1;
      chk("m_clk_3KHz",   clk_3KHz,     ((m_n % P) >= (P / 2)));
      chk("m_prescale",   dbg_prescale, m_n % P);
      chk("m_irq_n",      irq_n,        !m_pending);
      chk("m_cpu_rst",    cpu_rst,      m_hold);
      chk("m_wdog_fired", wdog_fired,   m_fired);
      chk("m_overrun",    irq_overrun,  m_ovr);
      chk("m_state",      wdog_state,   m_hold ? WD_HOLD : WD_RUN);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      rst = 1'b1; bus.clk_en = 1'b1; bus.we = 1'b0; bus.addr = 16'h0000; wdog_disable = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   task automatic run_until_tick(input string tag);
      bit got;
      got = 0;
      for (int k = 0; k < 4 * P * DIVP && !got; k++) begin
         cycle();
         got = m_tick;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL %s: no period tick within budget", tag);
      end
   endtask

   task automatic run_until_pre_tick(input string tag);
      int k;
      k = 0;
      while (!tick_at(m_n + 1) && k < 4 * P * DIVP) begin
         cycle();
         k++;
      end
      if (!tick_at(m_n + 1)) begin
         checks++; failures++;
         $display("FAIL %s: tick cycle not reached within budget", tag);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          reps;
      bit          r;
      bit          en;
      bit          we;
      logic [15:0] a;
      bit          dis;
      bit          e_clk;
      bit          e_irq_n;
      bit          e_rst;
      bit          e_fired;
      bit          e_ovr;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input int reps, input bit r, input bit en, input bit we,
                               input logic [15:0] a, input bit dis, input bit e_clk,
                               input bit e_irq_n, input bit e_rst, input bit e_fired,
                               input bit e_ovr);
      vec_t v;
      v.reps = reps; v.r = r; v.en = en; v.we = we; v.a = a; v.dis = dis;
      v.e_clk = e_clk; v.e_irq_n = e_irq_n; v.e_rst = e_rst; v.e_fired = e_fired; v.e_ovr = e_ovr;
      return v;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      set_idle();
      rst = 1'b0;

      // Enable count in comments is enables since the last reset.
      vt.push_back(mk( 2, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // reset
      vt.push_back(mk(10, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // 1..10
      vt.push_back(mk( 2, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // reset mid-count
      vt.push_back(mk(15, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // 1..15
      vt.push_back(mk( 1, 1, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 0)); // 16 first rise
      vt.push_back(mk( 4, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0)); // clk_en=0 holds
      vt.push_back(mk(15, 1, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 0)); // 17..31
      vt.push_back(mk( 1, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // 32 wrap
      vt.push_back(mk(15, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // 33..47
      vt.push_back(mk( 1, 1, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 0)); // 48 second rise
      vt.push_back(mk(15, 1, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 0)); // 49..63
      vt.push_back(mk(16, 1, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0)); // 64..79
      vt.push_back(mk( 1, 1, 1, 0, 16'h0000, 0, 1, 0, 0, 0, 0)); // 80 period tick
      vt.push_back(mk( 2, 1, 0, 1, WA,       0, 1, 0, 0, 0, 0)); // write without clk_en
      vt.push_back(mk( 1, 1, 1, 1, 16'h5001, 0, 1, 0, 0, 0, 0)); // 81 wrong address
      vt.push_back(mk( 1, 1, 1, 1, AA,       0, 1, 1, 0, 0, 0)); // 82 ack
      vt.push_back(mk( 1, 1, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 0)); // 83

      foreach (vt[i]) begin
         for (int k = 0; k < vt[i].reps; k++) begin
            rst = vt[i].r; bus.clk_en = vt[i].en; bus.we = vt[i].we;
            bus.addr = vt[i].a; wdog_disable = vt[i].dis;
            cycle();
            chk($sformatf("vec%0d_clk_3KHz", i),    clk_3KHz,    vt[i].e_clk);
            chk($sformatf("vec%0d_irq_n", i),       irq_n,       vt[i].e_irq_n);
            chk($sformatf("vec%0d_cpu_rst", i),     cpu_rst,     vt[i].e_rst);
            chk($sformatf("vec%0d_wdog_fired", i),  wdog_fired,  vt[i].e_fired);
            chk($sformatf("vec%0d_irq_overrun", i), irq_overrun, vt[i].e_ovr);
         end
      end
      set_idle();

      // Reset mid-count restarts the prescaler from zero.
      for (int k = 0; k < 7; k++) cycle();
      do_reset();
      chk("rst_prescale_zero", dbg_prescale, 0);
      chk("rst_clk_3KHz",      clk_3KHz,     0);
      chk("rst_irq_n",         irq_n,        1);
      chk("rst_cpu_rst",       cpu_rst,      0);
      chk("rst_fired",         wdog_fired,   0);
      cycle();
      chk("rst_prescale_one",  dbg_prescale, 1);

      // Ack in the exact tick cycle: set wins. Then a missed period overruns.
      do_reset();
      run_until_pre_tick("ack_same_tick");
      bus.we = 1'b1; bus.addr = AA;
      cycle();
      bus.we = 1'b0;
      chk("ack_same_tick_irq_n", irq_n, 0);
      run_until_tick("overrun_tick");
      chk("overrun_flag",  irq_overrun, 1);
      chk("overrun_irq_n", irq_n,       0);
      bus.we = 1'b1; bus.addr = AA;
      cycle();
      bus.we = 1'b0;
      chk("overrun_ack_irq_n", irq_n,       1);
      chk("overrun_sticky",    irq_overrun, 1);

      // Starved watchdog: fires on the WL-th tick and holds RH enables.
      do_reset();
      for (int p = 0; p < WL; p++) run_until_tick("starve_tick");
      chk("fire_cpu_rst", cpu_rst,    1);
      chk("fire_fired",   wdog_fired, 1);
      chk("fire_irq_n",   irq_n,      1);
      chk("fire_state",   wdog_state, WD_HOLD);
      for (int k = 1; k < RH; k++) begin
         // Kicks and disable during the hold must not shorten it.
         bus.we = (k == 2); bus.addr = WA; wdog_disable = (k >= 3);
         cycle();
         chk("hold_cpu_rst", cpu_rst, 1);
         chk("hold_irq_n",   irq_n,   1);
      end
      set_idle();
      cycle();
      chk("release_cpu_rst", cpu_rst,    0);
      chk("release_fired",   wdog_fired, 1);
      chk("release_state",   wdog_state, WD_RUN);

      // Reset asserted in the middle of a second hold.
      for (int p = 0; p < WL; p++) run_until_tick("refire_tick");
      chk("refire_cpu_rst", cpu_rst, 1);
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      chk("hold_rst_cpu_rst", cpu_rst,     0);
      chk("hold_rst_fired",   wdog_fired,  0);
      chk("hold_rst_state",   wdog_state,  WD_RUN);
      chk("hold_rst_irq_n",   irq_n,       1);
      chk("hold_rst_overrun", irq_overrun, 0);
      rst = 1'b1;

      // Regular kicks keep the CPU alive.
      do_reset();
      rst_seen = 0;
      for (int p = 0; p < 100; p++) begin
         run_until_tick("kick_tick");
         bus.we = 1'b1; bus.addr = WA;
         cycle();
         bus.we = 1'b0;
      end
      chk("kicked_no_cpu_rst", rst_seen, 0);

      // Disabled watchdog never fires.
      rst_seen = 0;
      wdog_disable = 1'b1;
      for (int p = 0; p < 20; p++) run_until_tick("disable_tick");
      chk("disabled_no_cpu_rst", rst_seen, 0);
      set_idle();

      // Random traffic with frequent writes.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom_range(0, 599) != 0);
         bus.clk_en   = ($urandom_range(0, 9) < 8);
         bus.we       = ($urandom_range(0, 19) == 0);
         bus.addr     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : WA;
         wdog_disable = ($urandom_range(0, 29) == 0);
         cycle();
      end

      // Random traffic with rare writes so the watchdog can starve.
      set_idle();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom_range(0, 2999) != 0);
         bus.clk_en   = ($urandom_range(0, 9) < 8);
         bus.we       = ($urandom_range(0, 499) == 0);
         bus.addr     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : WA;
         wdog_disable = 1'b0;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
